// File: rtl/collective_dispatch_if.sv
// Flit streams around the collective dispatcher: injection side (in_*) and
// router side (out_*), each a valid/ready handshake.
interface collective_dispatch_if #(
  parameter int FLIT_W  = 73,
  parameter int CHILD_W = 3
);
  logic [FLIT_W-1:0]         in_flit;
  logic                      in_valid;
  logic                      in_ready;
  logic [FLIT_W+CHILD_W-1:0] out_flit;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_flit, in_valid, out_ready,
    input  in_ready, out_flit, out_valid
  );

  modport slave (
    input  in_flit, in_valid, out_ready,
    output in_ready, out_flit, out_valid
  );
endinterface

// File: rtl/collective_dispatch.sv
// Per-node collective dispatcher: takes one collective flit, looks up its
// communicator entry and emits 0..MAX_PEERS routed flits with children appended.
module collective_dispatch #(
  parameter int FLIT_W     = 73,
  parameter int CHILD_W    = 3,
  parameter int COORD_W    = 3,
  parameter int CTX_W      = 8,
  parameter int COMM_DEPTH = 4,
  parameter int MAX_PEERS  = 3,
  parameter logic [3*COORD_W-1:0] MY_ADDR = '0,
  localparam int CFG_AW = $clog2(COMM_DEPTH),
  localparam int ENT_W  = 1 + 3*COORD_W + CHILD_W + 4 + MAX_PEERS*3*COORD_W
) (
  input  logic              clk,
  input  logic              rst,
  collective_dispatch_if.slave bus,
  input  logic              cfg_we,
  input  logic [CFG_AW-1:0] cfg_addr,
  input  logic [ENT_W-1:0]  cfg_data,
  output logic              busy,
  output logic              err_ctx
);

  localparam int ADDR_W  = 3*COORD_W;
  localparam int TAG_W   = 4;
  localparam int ALG_W   = 2;
  localparam int VALID_B = FLIT_W - 1;
  localparam int DST_LSB = VALID_B - ADDR_W;
  localparam int SRC_LSB = DST_LSB - ADDR_W;
  localparam int CTX_LSB = SRC_LSB - CTX_W;
  localparam int TAG_LSB = CTX_LSB - TAG_W;
  localparam int ALG_LSB = TAG_LSB - ALG_W;
  localparam int IDX_W   = (MAX_PEERS > 1) ? $clog2(MAX_PEERS) : 1;
  localparam int CNT_W   = $clog2(MAX_PEERS + 1);

  typedef struct packed {
    logic                               en;
    logic [ADDR_W-1:0]                  local_rank;
    logic [CHILD_W-1:0]                 children;
    logic [3:0]                         lg_commsize;
    logic [MAX_PEERS-1:0][ADDR_W-1:0]   peer;
  } entry_t;

  typedef enum logic [1:0] {IDLE, LOOKUP, SEND} state_t;
  typedef enum logic [1:0] {ALG_UPTREE, ALG_BCAST, ALG_RING, ALG_DOUBLING} alg_t;

  state_t                           state_q, state_d;
  entry_t                           table_q [COMM_DEPTH];
  logic [FLIT_W-1:0]                flit_q;
  logic [CHILD_W-1:0]               children_q;
  logic [MAX_PEERS-1:0][ADDR_W-1:0] peer_q;
  logic [CNT_W-1:0]                 n_q, lk_n;
  logic [IDX_W-1:0]                 idx_q, slot;
  entry_t                           lk_entry;
  logic [CTX_W-1:0]                 ctx;
  logic                             ctx_ok, flit_live, last, in_ready, out_valid;
  alg_t                             alg;
  logic [FLIT_W-1:0]                flit_o;
  logic [CHILD_W-1:0]               children_o;
  logic                             unused_rank;

  function automatic logic [CNT_W-1:0] sat_count(input logic [3:0] v);
    if (v > 4'(MAX_PEERS)) return CNT_W'(MAX_PEERS);
    return CNT_W'(v);
  endfunction

  assign ctx         = flit_q[CTX_LSB +: CTX_W];
  assign alg         = alg_t'(flit_q[ALG_LSB +: ALG_W]);
  assign flit_live   = flit_q[VALID_B];
  assign lk_entry    = table_q[ctx[CFG_AW-1:0]];
  assign ctx_ok      = ({1'b0, ctx} < (CTX_W+1)'(COMM_DEPTH)) && lk_entry.en;
  assign last        = (CNT_W'(idx_q) == n_q - CNT_W'(1));
  assign unused_rank = ^lk_entry.local_rank;

  // NOTE: the table carries a reset because every entry must read en=0 after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < COMM_DEPTH; i++) table_q[i] <= '0;
    end else if (cfg_we && ({1'b0, cfg_addr} < (CFG_AW+1)'(COMM_DEPTH))) begin
      table_q[cfg_addr] <= entry_t'(cfg_data);
    end
  end

  // NOTE: <= means LOOKUP latches the pre-edge table, so a same-cycle cfg_we sees the old entry.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    lk_n = '0;
    if (flit_live && ctx_ok) begin
      case (alg)
        ALG_UPTREE:   lk_n = CNT_W'(1);
        ALG_BCAST:    lk_n = sat_count(4'(lk_entry.children));
        ALG_RING:     lk_n = CNT_W'(1);
        ALG_DOUBLING: lk_n = sat_count(lk_entry.lg_commsize);
        default:      lk_n = '0;
      endcase
    end
  end

  // NOTE: every output is defaulted first so no branch leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    err_ctx   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (bus.in_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        err_ctx = flit_live && !ctx_ok;
        state_d = (lk_n == '0) ? IDLE : SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        if (bus.out_ready && last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flit_q     <= '0;
      children_q <= '0;
      peer_q     <= '0;
      n_q        <= '0;
      idx_q      <= '0;
    end else begin
      case (state_q)
        IDLE:   if (bus.in_valid) flit_q <= bus.in_flit;
        LOOKUP: begin
          children_q <= lk_entry.children;
          peer_q     <= lk_entry.peer;
          n_q        <= lk_n;
          idx_q      <= '0;
        end
        SEND: begin
          if (bus.out_ready && !last && idx_q != IDX_W'(MAX_PEERS - 1))
            idx_q <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Peer slot for the current index; doubling walks the peer list from the far end.
  always_comb begin
    slot = '0;
    case (alg)
      ALG_UPTREE:   slot = '0;
      ALG_BCAST:    slot = idx_q;
      ALG_RING:     slot = IDX_W'((MAX_PEERS == 1) ? 0 : 1);
      ALG_DOUBLING: slot = IDX_W'(n_q - CNT_W'(1) - CNT_W'(idx_q));
      default:      slot = '0;
    endcase
  end

  always_comb begin
    flit_o                       = flit_q;
    flit_o[VALID_B]              = 1'b1;
    flit_o[DST_LSB +: ADDR_W]    = peer_q[slot];
    flit_o[SRC_LSB +: ADDR_W]    = MY_ADDR;
    if (alg == ALG_DOUBLING) flit_o[TAG_LSB +: TAG_W] = TAG_W'(idx_q);
    children_o = (alg == ALG_UPTREE) ? children_q : '0;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_flit  = out_valid ? {children_o, flit_o} : '0;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_collective_dispatch.sv
// Directed bench for collective_dispatch: reset, uptree, bcast with stalls,
// ring, doubling, bad contexts and the cfg/LOOKUP race.
module tb_collective_dispatch;

  localparam int FLIT_W  = 73;
  localparam int CHILD_W = 3;
  localparam int ENT_W   = 44;
  localparam logic [8:0] MY = 9'o123;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  collective_dispatch_if #(.FLIT_W(FLIT_W), .CHILD_W(CHILD_W)) bus();
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [ENT_W-1:0] cfg_data;
  logic             busy, err_ctx;

  collective_dispatch #(.MY_ADDR(MY)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .busy     (busy),
    .err_ctx  (err_ctx)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [FLIT_W+CHILD_W-1:0] exp_q [3];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk_flit(input logic v, input logic [8:0] dst,
      input logic [8:0] src, input logic [7:0] ctx, input logic [3:0] tag,
      input logic [1:0] alg, input logic [7:0] op, input logic [31:0] pay);
    return {v, dst, src, ctx, tag, alg, op, pay};
  endfunction

  function automatic logic [ENT_W-1:0] mk_ent(input logic en, input logic [2:0] ch,
      input logic [3:0] lg, input logic [8:0] p2, input logic [8:0] p1, input logic [8:0] p0);
    return {en, 9'd0, ch, lg, p2, p1, p0};
  endfunction

  // Expected routed flit: fields taken from the injected flit, dst/src/tag replaced.
  function automatic logic [FLIT_W+CHILD_W-1:0] exp_out(input logic [2:0] ch,
      input logic [8:0] dst, input logic [FLIT_W-1:0] f, input logic [3:0] tag);
    return {ch, mk_flit(1'b1, dst, MY, f[53:46], tag, f[41:40], f[39:32], f[31:0])};
  endfunction

  task automatic cfg_write(input logic [1:0] a, input logic [ENT_W-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Returns at the negedge of the cycle after acceptance (LOOKUP).
  task automatic send_flit(input logic [FLIT_W-1:0] f);
    int w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_send", bus.in_ready, 1'b1);
    bus.in_flit = f; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_flit = '0;
  endtask

  // Starts at a SEND-cycle negedge; pat bit (cycle%8) drives out_ready.
  task automatic burst_from_send(input int n, input logic [7:0] pat);
    int k = 0;
    int cyc = 0;
    while (k < n && cyc < 40) begin
      bus.out_ready = pat[cyc % 8];
      check($sformatf("burst_valid_%0d", k), bus.out_valid, 1'b1);
      check($sformatf("burst_flit_%0d", k), bus.out_flit, exp_q[k]);
      if (bus.out_valid && bus.out_ready) k++;
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    check("burst_count", k, n);
    check("post_burst_valid", bus.out_valid, 1'b0);
    check("post_burst_in_ready", bus.in_ready, 1'b1);
  endtask

  task automatic expect_burst(input int n, input logic [7:0] pat);
    check("lookup_valid", bus.out_valid, 1'b0);
    check("lookup_busy", busy, 1'b1);
    @(negedge clk);
    burst_from_send(n, pat);
  endtask

  task automatic expect_none(input logic err);
    check("none_err_pulse", err_ctx, err);
    check("none_lookup_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    check("none_err_clear", err_ctx, 1'b0);
    check("none_valid", bus.out_valid, 1'b0);
    check("none_busy", busy, 1'b0);
    check("none_in_ready", bus.in_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [FLIT_W-1:0] f;
    bus.in_flit = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_flit", bus.out_flit, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_ctx, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("release_in_ready", bus.in_ready, 1'b1);

    // Uptree: children field carried, dst=peer0, src rewritten
    cfg_write(2'd0, mk_ent(1'b1, 3'd3, 4'd0, 9'o000, 9'o000, 9'o001));
    f = mk_flit(1'b1, 9'o777, 9'o555, 8'd0, 4'h5, 2'd0, 8'h11, 32'hDEADBEEF);
    exp_q[0] = exp_out(3'd3, 9'o001, f, 4'h5);
    send_flit(f);
    expect_burst(1, 8'hFF);

    // Broadcast with back-pressure
    cfg_write(2'd1, mk_ent(1'b1, 3'd3, 4'd0, 9'o004, 9'o002, 9'o001));
    f = mk_flit(1'b1, 9'o000, 9'o000, 8'd1, 4'h7, 2'd1, 8'h22, 32'h12345678);
    exp_q[0] = exp_out(3'd0, 9'o001, f, 4'h7);
    exp_q[1] = exp_out(3'd0, 9'o002, f, 4'h7);
    exp_q[2] = exp_out(3'd0, 9'o004, f, 4'h7);
    send_flit(f);
    expect_burst(3, 8'b1011_0010);

    // Ring: dst=peer1
    f = mk_flit(1'b1, 9'o000, 9'o000, 8'd1, 4'h3, 2'd2, 8'h33, 32'hCAFEF00D);
    exp_q[0] = exp_out(3'd0, 9'o002, f, 4'h3);
    send_flit(f);
    expect_burst(1, 8'hFF);

    // Broadcast with children=7 saturates to MAX_PEERS
    cfg_write(2'd2, mk_ent(1'b1, 3'd7, 4'd0, 9'o300, 9'o200, 9'o100));
    f = mk_flit(1'b1, 9'o000, 9'o000, 8'd2, 4'h1, 2'd1, 8'h44, 32'h0000_0001);
    exp_q[0] = exp_out(3'd0, 9'o100, f, 4'h1);
    exp_q[1] = exp_out(3'd0, 9'o200, f, 4'h1);
    exp_q[2] = exp_out(3'd0, 9'o300, f, 4'h1);
    send_flit(f);
    expect_burst(3, 8'hFF);

    // Recursive doubling, lg_commsize=3: dst C,B,A with tag 0,1,2
    cfg_write(2'd2, mk_ent(1'b1, 3'd0, 4'd3, 9'o030, 9'o020, 9'o010));
    f = mk_flit(1'b1, 9'o000, 9'o000, 8'd2, 4'h9, 2'd3, 8'h55, 32'hA5A5_5A5A);
    exp_q[0] = exp_out(3'd0, 9'o030, f, 4'd0);
    exp_q[1] = exp_out(3'd0, 9'o020, f, 4'd1);
    exp_q[2] = exp_out(3'd0, 9'o010, f, 4'd2);
    send_flit(f);
    expect_burst(3, 8'b1101_1101);

    // Doubling, lg_commsize=2: dst B,A with tag 0,1
    cfg_write(2'd2, mk_ent(1'b1, 3'd0, 4'd2, 9'o030, 9'o020, 9'o010));
    exp_q[0] = exp_out(3'd0, 9'o020, f, 4'd0);
    exp_q[1] = exp_out(3'd0, 9'o010, f, 4'd1);
    send_flit(f);
    expect_burst(2, 8'hFF);

    // Doubling, lg_commsize=0: no output, no error
    cfg_write(2'd2, mk_ent(1'b1, 3'd0, 4'd0, 9'o030, 9'o020, 9'o010));
    send_flit(f);
    expect_none(1'b0);

    // Bad contexts: out of range, and never-enabled entry
    send_flit(mk_flit(1'b1, 9'o000, 9'o000, 8'd5, 4'h0, 2'd0, 8'h00, 32'h0));
    expect_none(1'b1);
    send_flit(mk_flit(1'b1, 9'o000, 9'o000, 8'd3, 4'h0, 2'd1, 8'h00, 32'h0));
    expect_none(1'b1);

    // Flit with valid bit clear is swallowed silently
    send_flit(mk_flit(1'b0, 9'o000, 9'o000, 8'd0, 4'h0, 2'd0, 8'h00, 32'h0));
    expect_none(1'b0);

    // Config race: write during LOOKUP and during SEND, burst keeps old peers
    cfg_write(2'd0, mk_ent(1'b1, 3'd2, 4'd0, 9'o103, 9'o102, 9'o101));
    f = mk_flit(1'b1, 9'o000, 9'o000, 8'd0, 4'h1, 2'd1, 8'h66, 32'h0BAD_CAFE);
    exp_q[0] = exp_out(3'd0, 9'o101, f, 4'h1);
    exp_q[1] = exp_out(3'd0, 9'o102, f, 4'h1);
    send_flit(f);
    cfg_we = 1'b1; cfg_addr = 2'd0;
    cfg_data = mk_ent(1'b1, 3'd2, 4'd0, 9'o303, 9'o302, 9'o301);
    check("race_lookup_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    cfg_data = mk_ent(1'b1, 3'd2, 4'd0, 9'o203, 9'o202, 9'o201);
    bus.out_ready = 1'b0;
    check("race_send_flit", bus.out_flit, exp_q[0]);
    @(negedge clk);
    cfg_we = 1'b0;
    burst_from_send(2, 8'b1111_1110);
    exp_q[0] = exp_out(3'd0, 9'o201, f, 4'h1);
    exp_q[1] = exp_out(3'd0, 9'o202, f, 4'h1);
    send_flit(f);
    expect_burst(2, 8'hFF);

    // Reset mid-SEND aborts the burst and clears the table
    f = mk_flit(1'b1, 9'o000, 9'o000, 8'd1, 4'h2, 2'd1, 8'h77, 32'h1111_2222);
    send_flit(f);
    @(negedge clk);
    check("pre_rst_valid", bus.out_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", bus.out_valid, 1'b0);
    check("midrst_flit", bus.out_flit, '0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_in_ready", bus.in_ready, 1'b1);
    check("postrst_valid", bus.out_valid, 1'b0);
    send_flit(f);
    expect_none(1'b1);
    send_flit(mk_flit(1'b1, 9'o000, 9'o000, 8'd0, 4'h0, 2'd0, 8'h00, 32'h0));
    expect_none(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
